iir_biquad_cascade_tdm: RTL and testbench
=========================================

// Module: iir_biquad_cascade_tdm
// PURPOSE
//  Parametrised cascade of N_SEC biquad IIR sections sharing one time-multiplexed section datapath.
//  Each section applies a gain, then a direct-form-I biquad. Coefficients are runtime-loadable per section.
//  The block uses valid/ready handshakes on input and output, and saturates every section output.
//  It is the programmable successor to the fixed 8-section Q14 band-pass cascade in the lab filter chain.
// PARAMETERS
//  DW     16  sample width (signed two's complement)
//  CW     16  coefficient width (signed)
//  FRAC   14  coefficient fractional bits (Qx.FRAC)
//  N_SEC  8   number of cascaded sections (1..16)
//  SW     4   section index width; SW >= clog2(N_SEC), minimum 1
// PORTS
//  clk        in   1    single clock; all state updates on the rising edge
//  rst        in   1    reset, asynchronous and active-high
//  in_valid   in   1    x_in holds a valid sample
//  in_ready   out  1    block can accept a sample
//  x_in       in   DW   input sample
//  out_valid  out  1    y_out holds a valid result
//  out_ready  in   1    downstream accepts y_out
//  y_out      out  DW   filtered sample
//  cfg_we     in   1    coefficient write strobe
//  cfg_sec    in   SW   target section
//  cfg_idx    in   3    0=g 1=b0 2=b1 3=b2 4=a1 5=a2 (6,7 invalid)
//  cfg_data   in   CW   coefficient value
//  cfg_err    out  1    one-cycle pulse: write rejected
//  clr_state  in   1    zero all section delay lines (honoured in IDLE only)
//  sat_flag   out  1    sticky: some section output saturated
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state IDLE; in_ready=1; out_valid=0; y_out=0; cfg_err=0; sat_flag=0.
//   - Section counter, delay lines (w1,w2,y1,y2 per section) and all coefficients set to 0.
//   - Reset mid-RUN or mid-HOLD abandons the sample with no output.
//  Per-section arithmetic, for section s with input x:
//   - w = sat_DW((g*x) >>> FRAC)
//   - acc = b0*w + b1*w1 + b2*w2 - a1*y1 - a2*y2, accumulated in DW+CW+3 bits, no overflow
//   - y = sat_DW(acc >>> FRAC); arithmetic shift, truncation toward -inf
//   - Saturation clamps to +(2^(DW-1)-1) / -2^(DW-1); any clamp sets sat_flag.
//   - After computing s: w2<=w1, w1<=w, y2<=y1, y1<=y. y is the input to section s+1.
//  FSM:
//   - IDLE: in_ready=1. in_valid&in_ready -> load work register with x_in, sec=0, go RUN.
//   - RUN: in_ready=0. One section per cycle; result goes to work register, sec increments.
//     At sec=N_SEC-1 the result is loaded into y_out, out_valid<=1, go HOLD.
//   - HOLD: in_ready=0; y_out stable. out_ready=1 -> out_valid<=0, go IDLE.
//     No new input is accepted in the HOLD->IDLE cycle.
//  Timing:
//   - Latency: out_valid rises N_SEC cycles after the input acceptance edge.
//   - Max throughput: 1 sample per N_SEC+2 cycles.
//  Configuration:
//   - Writes apply only in IDLE, taking effect on the next edge.
//   - cfg_we with state!=IDLE, cfg_sec>=N_SEC or cfg_idx>5: no write; cfg_err=1 for one cycle.
//   - cfg_we coincident with in_valid acceptance in IDLE: the write commits and the sample uses the new value.
//  clr_state:
//   - In IDLE: zeroes all delay lines and sat_flag on the next edge.
//   - Ignored outside IDLE. clr_state with in_valid in IDLE: clear wins and the sample is not accepted (in_ready=0 that cycle).
// TESTING
//  T1 N_SEC=2, both sections g=b0=16384, others 0; x_in=1000 -> y_out=1000, out_valid exactly 2 cycles after accept.
//  T2 N_SEC=1, g=16384, b0=16384, a1=-8192; impulse 16384 then 0,0 -> y_out 16384, 8192, 4096.
//  T3 g=16384, b0=32767; x_in=30000 -> y_out=32767, sat_flag=1. x_in=-30000 -> y_out=-32768.
//  T4 hold out_ready=0 for 10 cycles after out_valid -> y_out stable, in_ready=0, in_valid ignored. Release -> IDLE next cycle.
//  T5 cfg_we during RUN, or cfg_idx=6 -> cfg_err one-cycle pulse, coefficient unchanged (verify via T1 output).
//  T6 rst=1 mid-RUN (sec=3) -> out_valid=0, y_out=0 immediately. Next sample with reloaded coeffs matches a fresh-run reference model.

Source files
------------

// File: rtl/iir_biquad_cascade_tdm.sv
// Cascade of N_SEC gain + direct-form-I biquad sections evaluated one section per clock
// on a shared datapath, with runtime-loadable coefficients and saturating section outputs.
module iir_biquad_cascade_tdm #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int FRAC  = 14,
  parameter int N_SEC = 8,
  parameter int SW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y_out,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_sec,
  input  logic [2:0]    cfg_idx,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_err,
  input  logic          clr_state,
  output logic          sat_flag
);

  // Handshakes: a sample moves on a rising edge where in_valid && in_ready (input side)
  // or out_valid && out_ready (output side); y_out is held unchanged while out_valid waits.

  localparam int AW    = DW + CW + 3;
  localparam int NSLOT = 1 << SW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [SW:0] LAST_SEC = (SW+1)'(N_SEC - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]           state;
  logic [SW-1:0]        sec;
  logic signed [DW-1:0] work;

  // Storage is sized to the full section/index address space so every write address is
  // in range; slots at or above N_SEC and indices 6/7 are never written and stay zero.
  logic signed [CW-1:0] coef [NSLOT][8];
  logic signed [DW-1:0] w1   [NSLOT];
  logic signed [DW-1:0] w2   [NSLOT];
  logic signed [DW-1:0] y1   [NSLOT];
  logic signed [DW-1:0] y2   [NSLOT];

  logic signed [AW-1:0] gx;
  logic signed [AW-1:0] acc;
  logic signed [DW-1:0] w_cur;
  logic signed [DW-1:0] y_cur;
  logic                 w_sat;
  logic                 y_sat;
  logic                 cfg_ok;
  logic                 is_last;

  function automatic logic [DW:0] sat_dw(input logic signed [AW-1:0] v);
    if (v > SAT_MAX)      return {1'b1, SAT_MAX[DW-1:0]};
    else if (v < SAT_MIN) return {1'b1, SAT_MIN[DW-1:0]};
    else                  return {1'b0, v[DW-1:0]};
  endfunction

  always_comb begin
    gx = (AW'(coef[sec][0]) * AW'(work)) >>> FRAC;
    {w_sat, w_cur} = sat_dw(gx);
    acc = AW'(coef[sec][1]) * AW'(w_cur)
        + AW'(coef[sec][2]) * AW'(w1[sec])
        + AW'(coef[sec][3]) * AW'(w2[sec])
        - AW'(coef[sec][4]) * AW'(y1[sec])
        - AW'(coef[sec][5]) * AW'(y2[sec]);
    {y_sat, y_cur} = sat_dw(acc >>> FRAC);
  end

  // A clear request in IDLE takes priority over accepting a sample.
  assign in_ready = (state == IDLE) && !clr_state;
  assign cfg_ok   = cfg_we && (state == IDLE) && ({1'b0, cfg_sec} <= LAST_SEC)
                    && (cfg_idx <= 3'd5);
  assign is_last  = ({1'b0, sec} == LAST_SEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sec       <= '0;
      work      <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      sat_flag  <= 1'b0;
      for (int s = 0; s < NSLOT; s++) begin
        w1[s] <= '0;
        w2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
        for (int i = 0; i < 8; i++) coef[s][i] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) coef[cfg_sec][cfg_idx] <= cfg_data;

      case (state)
        IDLE: begin
          if (clr_state) begin
            sat_flag <= 1'b0;
            for (int s = 0; s < NSLOT; s++) begin
              w1[s] <= '0;
              w2[s] <= '0;
              y1[s] <= '0;
              y2[s] <= '0;
            end
          end else if (in_valid) begin
            work  <= x_in;
            sec   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          w2[sec] <= w1[sec];
          w1[sec] <= w_cur;
          y2[sec] <= y1[sec];
          y1[sec] <= y_cur;
          work    <= y_cur;
          sec     <= sec + 1'b1;
          if (w_sat || y_sat) sat_flag <= 1'b1;
          if (is_last) begin
            y_out     <= y_cur;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade_tdm.sv
// Directed bench for iir_biquad_cascade_tdm with a 4-section cascade; unused sections are
// programmed as unity pass-through so hand-computed single-section results carry to y_out.
module tb_iir_biquad_cascade_tdm;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int FRAC = 14;
  localparam int NS   = 4;
  localparam int SW   = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] y_out;
  logic                 cfg_we;
  logic [SW-1:0]        cfg_sec;
  logic [2:0]           cfg_idx;
  logic signed [CW-1:0] cfg_data;
  logic                 cfg_err;
  logic                 clr_state;
  logic                 sat_flag;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  iir_biquad_cascade_tdm #(
    .DW(DW), .CW(CW), .FRAC(FRAC), .N_SEC(NS), .SW(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .cfg_we(cfg_we), .cfg_sec(cfg_sec), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .clr_state(clr_state), .sat_flag(sat_flag)
  );

  // ---------------- drivers ----------------
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0; clr_state = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg_write(input int s, input int idx, input int data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sec = SW'(s); cfg_idx = 3'(idx); cfg_data = CW'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_section(input int s, input int g, input int b0, input int b1,
                             input int b2, input int a1, input int a2);
    cfg_write(s, 0, g);
    cfg_write(s, 1, b0);
    cfg_write(s, 2, b1);
    cfg_write(s, 3, b2);
    cfg_write(s, 4, a1);
    cfg_write(s, 5, a2);
  endtask

  task automatic cfg_passthrough_from(input int first);
    for (int s = first; s < NS; s++) cfg_section(s, 16384, 16384, 0, 0, 0, 0);
  endtask

  task automatic send(input logic signed [DW-1:0] x);
    @(negedge clk);
    in_valid = 1'b1; x_in = x;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic signed [DW-1:0] y, output int lat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_out: out_valid=%b after %0d cycles, required 1", out_valid, n);
    end
    y = y_out;
    lat = n;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_sample(input logic signed [DW-1:0] x, output logic signed [DW-1:0] y,
                            output int lat);
    send(x);
    wait_out(y, lat);
    consume();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_out !== 16'sd0 ||
        cfg_err !== 1'b0 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b y_out=%0d cfg_err=%b sat_flag=%b, required 1 0 0 0 0",
               in_ready, out_valid, y_out, cfg_err, sat_flag);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency;
    logic signed [DW-1:0] y;
    int lat;
    do_reset();
    cfg_passthrough_from(0);
    run_sample(16'sd1000, y, lat);
    checks++;
    if (y !== 16'sd1000) begin errors++; $display("FAIL unity_pos: y=%0d required 1000", y); end
    checks++;
    if (lat !== NS) begin errors++; $display("FAIL latency: %0d cycles required %0d", lat, NS); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_consume: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    run_sample(-16'sd1000, y, lat);
    checks++;
    if (y !== -16'sd1000) begin errors++; $display("FAIL unity_neg: y=%0d required -1000", y); end
  endtask

  task automatic test_recursion;
    logic signed [DW-1:0] y;
    int lat;
    do_reset();
    cfg_section(0, 16384, 16384, 0, 0, -8192, 0);
    cfg_passthrough_from(1);
    run_sample(16'sd16384, y, lat);
    checks++;
    if (y !== 16'sd16384) begin errors++; $display("FAIL impulse_0: y=%0d required 16384", y); end
    run_sample(16'sd0, y, lat);
    checks++;
    if (y !== 16'sd8192) begin errors++; $display("FAIL impulse_1: y=%0d required 8192", y); end
    run_sample(16'sd0, y, lat);
    checks++;
    if (y !== 16'sd4096) begin errors++; $display("FAIL impulse_2: y=%0d required 4096", y); end
  endtask

  task automatic test_fir_clear;
    logic signed [DW-1:0] y;
    int lat;
    do_reset();
    cfg_section(0, 16384, 8192, 8192, 0, 0, 0);
    cfg_section(1, 8192, 16384, 0, 0, 0, 0);
    cfg_passthrough_from(2);
    run_sample(16'sd1000, y, lat);
    checks++;
    if (y !== 16'sd250) begin errors++; $display("FAIL fir_0: y=%0d required 250", y); end
    run_sample(16'sd3000, y, lat);
    checks++;
    if (y !== 16'sd1000) begin errors++; $display("FAIL fir_1: y=%0d required 1000", y); end
    // clear together with a sample: the clear is taken, the sample is refused
    @(negedge clk);
    clr_state = 1'b1; in_valid = 1'b1; x_in = 16'sd5;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_blocks_input: in_ready=%b required 0", in_ready); end
    @(negedge clk);
    clr_state = 1'b0; in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_no_sample: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    run_sample(-16'sd3, y, lat);
    checks++;
    if (y !== -16'sd1) begin errors++; $display("FAIL floor_shift: y=%0d required -1", y); end
  endtask

  task automatic test_saturation;
    logic signed [DW-1:0] y;
    int lat;
    do_reset();
    cfg_passthrough_from(0);
    cfg_write(0, 1, 32767);
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_init: sat_flag=%b required 0", sat_flag); end
    run_sample(16'sd30000, y, lat);
    checks++;
    if (y !== 16'sd32767) begin errors++; $display("FAIL sat_pos: y=%0d required 32767", y); end
    checks++;
    if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: sat_flag=%b required 1", sat_flag); end
    run_sample(-16'sd30000, y, lat);
    checks++;
    if (y !== -16'sd32768) begin errors++; $display("FAIL sat_neg: y=%0d required -32768", y); end
    @(negedge clk);
    clr_state = 1'b1;
    @(negedge clk);
    clr_state = 1'b0;
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear: sat_flag=%b required 0", sat_flag); end
    run_sample(16'sd10000, y, lat);
    checks++;
    if (y !== 16'sd19999 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL near_full: y=%0d sat_flag=%b required 19999 0", y, sat_flag);
    end
  endtask

  task automatic test_hold;
    logic signed [DW-1:0] y;
    int lat;
    do_reset();
    cfg_passthrough_from(0);
    send(16'sd1234);
    wait_out(y, lat);
    checks++;
    if (y !== 16'sd1234) begin errors++; $display("FAIL hold_value: y=%0d required 1234", y); end
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      x_in = DW'($urandom_range(0, 65535));
      @(negedge clk);
      checks++;
      if (y_out !== 16'sd1234 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle_%0d: y_out=%0d in_ready=%b out_valid=%b required 1234 0 1",
                 c, y_out, in_ready, out_valid);
      end
    end
    // in_valid stays high through the release edge and must not be taken there
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL release_no_accept: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_cfg_err;
    logic signed [DW-1:0] y;
    int lat;
    do_reset();
    cfg_passthrough_from(0);
    send(16'sd1000);
    cfg_we = 1'b1; cfg_sec = '0; cfg_idx = 3'd1; cfg_data = '0;
    @(negedge clk);
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_run: cfg_err=%b required 1", cfg_err); end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_run_pulse: cfg_err=%b required 0", cfg_err); end
    wait_out(y, lat);
    consume();
    checks++;
    if (y !== 16'sd1000) begin errors++; $display("FAIL err_run_nowrite: y=%0d required 1000", y); end
    cfg_write(0, 6, 0);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_idx6: cfg_err=%b required 1", cfg_err); end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_idx6_pulse: cfg_err=%b required 0", cfg_err); end
    cfg_write(NS, 1, 0);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_sec: cfg_err=%b required 1", cfg_err); end
    cfg_write(NS - 1, 1, 16384);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_valid_write: cfg_err=%b required 0", cfg_err); end
    run_sample(16'sd1000, y, lat);
    checks++;
    if (y !== 16'sd1000) begin errors++; $display("FAIL err_coef_kept: y=%0d required 1000", y); end
    // write lands on the same edge that accepts the sample and is used by it
    @(negedge clk);
    in_valid = 1'b1; x_in = 16'sd1000;
    cfg_we = 1'b1; cfg_sec = '0; cfg_idx = 3'd1; cfg_data = 16'sd8192;
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL coincident_err: cfg_err=%b required 0", cfg_err); end
    wait_out(y, lat);
    consume();
    checks++;
    if (y !== 16'sd500) begin errors++; $display("FAIL coincident_write: y=%0d required 500", y); end
  endtask

  task automatic test_reset_mid_run;
    logic signed [DW-1:0] y;
    int lat;
    do_reset();
    cfg_passthrough_from(0);
    run_sample(16'sd1000, y, lat);
    send(16'sd2000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y_out !== 16'sd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_reset: out_valid=%b y_out=%0d in_ready=%b required 0 0 1",
               out_valid, y_out, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abandoned_sample: out_valid=%b required 0", out_valid); end
    run_sample(16'sd1234, y, lat);
    checks++;
    if (y !== 16'sd0) begin errors++; $display("FAIL coef_zeroed: y=%0d required 0", y); end
    cfg_section(0, 16384, 16384, 0, 0, -8192, 0);
    cfg_passthrough_from(1);
    run_sample(16'sd16384, y, lat);
    checks++;
    if (y !== 16'sd16384) begin errors++; $display("FAIL fresh_0: y=%0d required 16384", y); end
    run_sample(16'sd0, y, lat);
    checks++;
    if (y !== 16'sd8192) begin errors++; $display("FAIL fresh_1: y=%0d required 8192", y); end
  endtask

  task automatic test_back_to_back;
    logic signed [DW-1:0] xs [3];
    logic signed [DW-1:0] ex [3];
    logic signed [DW-1:0] want;
    int acc_c[$];
    int idx;
    int got;
    logic accepting;
    xs[0] = 16'sd11;  xs[1] = -16'sd22; xs[2] = 16'sd33;
    ex[0] = 16'sd5;   ex[1] = -16'sd11; ex[2] = 16'sd16;
    do_reset();
    cfg_section(0, 8192, 16384, 0, 0, 0, 0);
    cfg_passthrough_from(1);
    idx = 0;
    got = 0;
    exp_q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    x_in = xs[0];
    for (int c = 0; c < 40; c++) begin
      accepting = in_valid && in_ready;
      if (accepting) begin
        acc_c.push_back(c);
        exp_q.push_back(ex[idx]);
      end
      if (out_valid === 1'b1) begin
        got++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'sd0;
        checks++;
        if (y_out !== want) begin errors++; $display("FAIL b2b_out_%0d: y=%0d required %0d", got, y_out, want); end
      end
      @(negedge clk);
      if (accepting) begin
        idx++;
        if (idx < 3) x_in = xs[idx];
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (got !== 3 || exp_q.size() !== 0 || acc_c.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count: outputs=%0d pending=%0d accepts=%0d required 3 0 3",
               got, exp_q.size(), acc_c.size());
    end else begin
      checks++;
      if (acc_c[1] - acc_c[0] !== NS + 2 || acc_c[2] - acc_c[1] !== NS + 2) begin
        errors++;
        $display("FAIL b2b_interval: gaps %0d %0d required %0d",
                 acc_c[1] - acc_c[0], acc_c[2] - acc_c[1], NS + 2);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    in_valid = 1'b0; out_ready = 1'b0; x_in = '0;
    cfg_we = 1'b0; cfg_sec = '0; cfg_idx = '0; cfg_data = '0; clr_state = 1'b0;
    test_reset();
    test_latency();
    test_recursion();
    test_fir_clear();
    test_saturation();
    test_hold();
    test_cfg_err();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
